// File: rtl/mem_copy_engine.sv
// Block copy engine: moves len 64-bit words from src to dst over data_bus,
// one word per READ/CAPTURE/WRITE triple, aborting on range or bus faults.
`ifndef INITIAL_PC
`define INITIAL_PC 64'h0000_0000_8000_0000
`endif
`ifndef MEM_END
`define MEM_END 64'h0000_0000_8FFF_FFFF
`endif

module mem_copy_engine #(
  parameter logic [63:0] MEM_START = `INITIAL_PC,
  parameter logic [63:0] MEM_END   = `MEM_END,
  parameter int          LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      src,
  input  logic [63:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [63:0]      err_addr,
  output logic [LEN_W-1:0] words_done,
  output logic             bus_rw,
  output logic [63:0]      bus_addr,
  output logic [63:0]      bus_write,
  input  logic [63:0]      bus_read,
  input  logic             bus_exception
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE, S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [63:0]      src_q, src_d;
  logic [63:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] wd_q, wd_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [63:0]      err_addr_q, err_addr_d;

  logic [64:0]      src_last, dst_last;
  logic             src_bad, dst_bad;
  logic [LEN_W-1:0] wd_inc;
  logic [63:0]      rd_addr, wr_addr;

  // 65-bit end addresses: a carry out of bit 63 always exceeds MEM_END.
  assign src_last = {1'b0, src} + {{(65-LEN_W){1'b0}}, len} - 65'd1;
  assign dst_last = {1'b0, dst} + {{(65-LEN_W){1'b0}}, len} - 65'd1;
  assign src_bad  = (src < MEM_START) || (src_last > {1'b0, MEM_END});
  assign dst_bad  = (dst < MEM_START) || (dst_last > {1'b0, MEM_END});

  assign wd_inc  = wd_q + {{(LEN_W-1){1'b0}}, 1'b1};
  assign rd_addr = src_q + {{(64-LEN_W){1'b0}}, wd_q};
  assign wr_addr = dst_q + {{(64-LEN_W){1'b0}}, wd_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      wd_q       <= '0;
      wdata_q    <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      wd_q       <= wd_d;
      wdata_q    <= wdata_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    wd_d       = wd_q;
    wdata_d    = wdata_q;
    err_addr_d = err_addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d      = src;
          dst_d      = dst;
          len_d      = len;
          wd_d       = '0;
          err_addr_d = '0;
          if (len == '0) begin
            state_d = S_DONE;
          end else if (src_bad) begin
            state_d    = S_ERROR;
            err_addr_d = src;
          end else if (dst_bad) begin
            state_d    = S_ERROR;
            err_addr_d = dst;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        wdata_d = bus_read;
        if (bus_exception) begin
          state_d    = S_ERROR;
          err_addr_d = rd_addr;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus_exception) begin
          state_d    = S_ERROR;
          err_addr_d = wr_addr;
        end else begin
          wd_d    = wd_inc;
          state_d = (wd_inc == len_q) ? S_DONE : S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    bus_rw   = 1'b0;
    bus_addr = '0;
    unique case (state_q)
      S_READ, S_CAPTURE: begin
        busy     = 1'b1;
        bus_addr = rd_addr;
      end
      S_WRITE: begin
        busy     = 1'b1;
        bus_rw   = 1'b1;
        bus_addr = wr_addr;
      end
      S_DONE:  done = 1'b1;
      S_ERROR: err  = 1'b1;
      default: ;
    endcase
  end

  assign bus_write  = wdata_q;
  assign err_addr   = err_addr_q;
  assign words_done = wd_q;

endmodule
